note_voice_allocator: RTL and testbench

Sequential voice allocator between the MIDI command decoder and the stepper-motor tone generators. It accepts 24-bit MIDI channel messages over a valid/ready handshake and keeps a table of NUM_VOICES voices, each holding a pitch, a velocity and an active flag. Note On messages are assigned to a free voice, to the voice already playing that pitch, or to the oldest voice when all voices are busy. Note Off messages release every voice playing the matching pitch. The voice table drives the per-motor frequency generators directly.

---
 rtl/note_voice_allocator_if.sv | 42 ++++
 rtl/note_voice_allocator.sv | 204 ++++++++++++++++++++
 tb/tb_note_voice_allocator.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_voice_allocator_if.sv
// note_voice_allocator_if
//   Bundles the command handshake from the MIDI decoder and the voice table
//   that feeds the stepper-motor tone generators.
//   cmd_valid    : upstream has a message on cmd_data
//   cmd_ready    : allocator can take a message this cycle
//   cmd_data     : [23:16] status, [15:8] pitch, [7:0] velocity
//   voice_active : one bit per voice, set while the voice sounds
//   voice_note   : voice i pitch at [8i+7:8i]
//   voice_vel    : voice i velocity at [8i+7:8i]
//   steal_pulse  : one-cycle pulse when a sounding voice was overwritten
// master = message source / voice consumer, slave = the allocator.
interface note_voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [23:0]             cmd_data;
    logic [NUM_VOICES-1:0]   voice_active;
    logic [8*NUM_VOICES-1:0] voice_note;
    logic [8*NUM_VOICES-1:0] voice_vel;
    logic                    steal_pulse;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  voice_active,
        input  voice_note,
        input  voice_vel,
        input  steal_pulse
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output voice_active,
        output voice_note,
        output voice_vel,
        output steal_pulse
    );
endinterface

// File: rtl/note_voice_allocator.sv
// note_voice_allocator
//   Sequential voice allocator. A Note On goes to the voice already playing
//   that pitch, else the lowest free voice, else the oldest sounding voice
//   (a steal). A Note Off releases every voice playing that pitch. Each
//   accepted note message walks the voice table one entry per cycle (SCAN)
//   and then commits a single table update (APPLY), so latency is fixed.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears the table and abandons any
//           message in flight
//   bus   : slave side of note_voice_allocator_if (handshake + voice table)
module note_voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    note_voice_allocator_if.slave bus
);
    localparam int            IW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    // Age counters stick at 255 so a long-held voice stays "oldest".
    function automatic logic [7:0] sat_inc(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction

    state_t                r_state;
    logic                  r_ready;
    logic                  r_steal;
    logic [IW-1:0]         r_idx;

    // Latched message
    logic                  r_is_on;
    logic [7:0]            r_pitch;
    logic [7:0]            r_vel_in;

    // Scan results
    logic                  r_match_found;
    logic [IW-1:0]         r_match_idx;
    logic                  r_free_found;
    logic [IW-1:0]         r_free_idx;
    logic                  r_old_found;
    logic [IW-1:0]         r_old_idx;
    logic [7:0]            r_old_age;
    logic [NUM_VOICES-1:0] r_offmask;

    // Voice table
    logic [NUM_VOICES-1:0] r_active;
    logic [7:0]            r_note [NUM_VOICES];
    logic [7:0]            r_vel  [NUM_VOICES];
    logic [7:0]            r_age  [NUM_VOICES];

    logic                  w_xfer;
    logic                  w_is_on;
    logic                  w_is_off;
    logic                  w_cur_active;
    logic                  w_cur_hit;
    logic                  w_cur_older;
    logic [IW-1:0]         w_target;
    logic                  w_steal;
    logic [8*NUM_VOICES-1:0] w_note_bus;
    logic [8*NUM_VOICES-1:0] w_vel_bus;
    logic                  w_unused_chan;

    // The MIDI channel nibble plays no part in allocation.
    assign w_unused_chan = ^bus.cmd_data[19:16];

    assign w_xfer   = bus.cmd_valid && r_ready;
    assign w_is_on  = (bus.cmd_data[23:20] == 4'h9) && (bus.cmd_data[7:0] != 8'h00);
    assign w_is_off = ((bus.cmd_data[23:20] == 4'h9) && (bus.cmd_data[7:0] == 8'h00)) ||
                      (bus.cmd_data[23:20] == 4'h8);

    // Voice currently under examination during SCAN.
    assign w_cur_active = r_active[r_idx];
    assign w_cur_hit    = w_cur_active && (r_note[r_idx] == r_pitch);
    // Strictly greater keeps the lowest index on an age tie.
    assign w_cur_older  = w_cur_active && (!r_old_found || (r_age[r_idx] > r_old_age));

    always_comb begin
        w_target = r_old_idx;
        w_steal  = 1'b0;
        if (r_match_found) begin
            w_target = r_match_idx;
        end else if (r_free_found) begin
            w_target = r_free_idx;
        end else begin
            w_steal  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_steal  <= 1'b0;
            r_idx    <= '0;
            r_active <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= 8'h00;
                r_vel[i]  <= 8'h00;
                r_age[i]  <= 8'h00;
            end
        end else begin
            r_steal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    // Non-note messages are consumed here and leave ready high.
                    if (w_xfer && (w_is_on || w_is_off)) begin
                        r_ready       <= 1'b0;
                        r_state       <= S_SCAN;
                        r_idx         <= '0;
                        r_is_on       <= w_is_on;
                        r_pitch       <= bus.cmd_data[15:8];
                        r_vel_in      <= bus.cmd_data[7:0];
                        r_match_found <= 1'b0;
                        r_match_idx   <= '0;
                        r_free_found  <= 1'b0;
                        r_free_idx    <= '0;
                        r_old_found   <= 1'b0;
                        r_old_idx     <= '0;
                        r_old_age     <= 8'h00;
                        r_offmask     <= '0;
                    end
                end

                S_SCAN: begin
                    if (w_cur_hit && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!w_cur_active && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    if (w_cur_older) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_idx;
                        r_old_age   <= r_age[r_idx];
                    end
                    r_offmask[r_idx] <= w_cur_hit;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_APPLY;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_APPLY: begin
                    if (r_is_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IW'(i) == w_target) begin
                                r_active[i] <= 1'b1;
                                r_note[i]   <= r_pitch;
                                r_vel[i]    <= r_vel_in;
                                r_age[i]    <= 8'h00;
                            end else if (r_active[i]) begin
                                r_age[i] <= sat_inc(r_age[i]);
                            end
                        end
                        r_steal <= w_steal;
                    end else begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (r_offmask[i]) begin
                                r_active[i] <= 1'b0;
                                r_note[i]   <= 8'h00;
                                r_vel[i]    <= 8'h00;
                                r_age[i]    <= 8'h00;
                            end
                        end
                    end
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_note_bus = '0;
        w_vel_bus  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_note_bus[8*i +: 8] = r_note[i];
            w_vel_bus[8*i +: 8]  = r_vel[i];
        end
    end

    assign bus.cmd_ready    = r_ready;
    assign bus.voice_active = r_active;
    assign bus.voice_note   = w_note_bus;
    assign bus.voice_vel    = w_vel_bus;
    assign bus.steal_pulse  = r_steal;
endmodule

// File: tb/tb_note_voice_allocator.sv
// tb_note_voice_allocator
//   Directed scenarios plus randomized messages for note_voice_allocator,
//   checked against a rule-level voice table model held in the bench.
module tb_note_voice_allocator;
    localparam int NV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_voice_allocator_if #(.NUM_VOICES(NV)) bus ();

    note_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference voice table
    bit         m_active [NV];
    logic [7:0] m_note   [NV];
    logic [7:0] m_vel    [NV];
    int         m_age    [NV];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 1'b0;
            m_note[i]   = 8'h00;
            m_vel[i]    = 8'h00;
            m_age[i]    = 0;
        end
    endfunction

    // Applies one message to the model; reports whether it is a note
    // message (costs a scan) and whether it steals a sounding voice.
    function automatic void model_msg(input logic [23:0] m, output bit is_note, output bit steal);
        int nib;
        int p;
        int v;
        int tgt;
        nib     = int'(m[23:20]);
        p       = int'(m[15:8]);
        v       = int'(m[7:0]);
        is_note = 1'b0;
        steal   = 1'b0;
        tgt     = -1;
        if (nib == 9 && v != 0) begin
            is_note = 1'b1;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_active[i] && int'(m_note[i]) == p) tgt = i;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_active[i]) tgt = i;
            if (tgt < 0) begin
                steal = 1'b1;
                tgt   = 0;
                for (int i = 1; i < NV; i++)
                    if (m_age[i] > m_age[tgt]) tgt = i;
            end
            for (int i = 0; i < NV; i++) begin
                if (i == tgt) begin
                    m_active[i] = 1'b1;
                    m_note[i]   = 8'(p);
                    m_vel[i]    = 8'(v);
                    m_age[i]    = 0;
                end else if (m_active[i]) begin
                    m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
                end
            end
        end else if (nib == 9 || nib == 8) begin
            is_note = 1'b1;
            for (int i = 0; i < NV; i++) begin
                if (m_active[i] && int'(m_note[i]) == p) begin
                    m_active[i] = 1'b0;
                    m_note[i]   = 8'h00;
                    m_vel[i]    = 8'h00;
                    m_age[i]    = 0;
                end
            end
        end
    endfunction

    function automatic logic [63:0] pk_act();
        logic [63:0] r = '0;
        for (int i = 0; i < NV; i++) r[i] = m_active[i];
        return r;
    endfunction

    function automatic logic [63:0] pk_note();
        logic [63:0] r = '0;
        for (int i = 0; i < NV; i++) r[8*i +: 8] = m_note[i];
        return r;
    endfunction

    function automatic logic [63:0] pk_vel();
        logic [63:0] r = '0;
        for (int i = 0; i < NV; i++) r[8*i +: 8] = m_vel[i];
        return r;
    endfunction

    task automatic check_table(input string tag);
        check({tag, ".active"}, 64'(bus.voice_active), pk_act());
        check({tag, ".note"},   64'(bus.voice_note),   pk_note());
        check({tag, ".vel"},    64'(bus.voice_vel),    pk_vel());
    endtask

    // Called and returns at a negedge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check({tag, ".rdy_in_reset"}, 64'(bus.cmd_ready), 64'd0);
        check({tag, ".steal"}, 64'(bus.steal_pulse), 64'd0);
        check_table({tag, ".in_reset"});
        reset = 1'b0;
        @(negedge clk);
        check({tag, ".rdy_after"}, 64'(bus.cmd_ready), 64'd1);
    endtask

    // Sends one message and watches the whole transaction window.
    task automatic send(input logic [23:0] m, input string tag);
        bit          is_note;
        bit          st;
        bit          stable;
        int          waitc;
        int          lowc;
        int          stc;
        logic [63:0] pre_a;
        logic [63:0] pre_n;
        logic [63:0] pre_v;
        pre_a = pk_act();
        pre_n = pk_note();
        pre_v = pk_vel();
        model_msg(m, is_note, st);
        waitc = 0;
        while (bus.cmd_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, ".rdy_wait"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = m;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 24'($urandom);
        lowc   = 0;
        stc    = 0;
        stable = 1'b1;
        for (int k = 0; k < NV + 3; k++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b0) begin
                lowc++;
                if (64'(bus.voice_active) !== pre_a || 64'(bus.voice_note) !== pre_n ||
                    64'(bus.voice_vel) !== pre_v)
                    stable = 1'b0;
            end
            if (bus.steal_pulse === 1'b1) stc++;
        end
        check({tag, ".rdy_low_cycles"}, 64'(lowc), is_note ? 64'(NV + 1) : 64'd0);
        check({tag, ".steal_cycles"}, 64'(stc), st ? 64'd1 : 64'd0);
        check({tag, ".held_during_scan"}, 64'(stable), 64'd1);
        check_table(tag);
    endtask

    logic [7:0] pool [6];

    initial begin
        logic [23:0] m;
        logic [3:0]  nib;
        int          sel;
        pool = '{8'h3C, 8'h40, 8'hBC, 8'h43, 8'hC0, 8'h48};
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 24'h0;
        @(negedge clk);

        // 1: first Note On after reset
        do_reset("s1.reset");
        send(24'h903C64, "s1.on");
        check("s1.v0_note", 64'(bus.voice_note[7:0]), 64'h3C);
        check("s1.v0_vel",  64'(bus.voice_vel[7:0]),  64'h64);

        // 2: fill in order, then steal the oldest
        send(24'h903C40, "s2.a");
        send(24'h904040, "s2.b");
        send(24'h904340, "s2.c");
        send(24'h904840, "s2.d");
        check("s2.full", 64'(bus.voice_active), 64'hF);
        send(24'h904C50, "s2.steal");
        check("s2.v0_note", 64'(bus.voice_note[7:0]), 64'h4C);

        // 3: Note Off frees voice 1, next On reuses it
        send(24'h804000, "s3.off");
        send(24'h914F22, "s3.on");
        check("s3.v1_note", 64'(bus.voice_note[15:8]), 64'h4F);

        // 4: velocity-zero Note On is a release; unmatched Off is a no-op
        send(24'h904300, "s4.vel0");
        send(24'h807700, "s4.nomatch");

        // 5: retrigger of a sounding pitch, then ages decide the next steal
        do_reset("s5.reset");
        send(24'h903C64, "s5.a");
        send(24'h904040, "s5.b");
        send(24'h904340, "s5.c");
        send(24'h903C7F, "s5.retrig");
        send(24'h904840, "s5.d");
        send(24'h904C50, "s5.steal");

        // Age saturation and tie-break on equal saturated ages
        do_reset("sat.reset");
        send(24'h901011, "sat.a");
        send(24'h902022, "sat.b");
        send(24'h903033, "sat.c");
        send(24'h904044, "sat.d");
        for (int k = 0; k < 253; k++) send(24'h904045, "sat.hold");
        send(24'h905055, "sat.steal1");
        send(24'h906066, "sat.steal2");

        // Randomized traffic over a small pitch pool (bit 7 variants included)
        do_reset("rnd.reset");
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            m[15:8] = pool[$urandom_range(0, 5)];
            m[19:16] = 4'($urandom);
            m[7:0] = 8'($urandom_range(1, 255));
            if (sel <= 4)      nib = 4'h9;
            else if (sel == 5) begin nib = 4'h9; m[7:0] = 8'h00; end
            else if (sel <= 7) nib = 4'h8;
            else begin
                nib = 4'($urandom_range(10, 15));
            end
            m[23:20] = nib;
            send(m, "rnd");
        end

        // 6: ignored message, back-to-back transfer, reset during SCAN
        send(24'hB01234, "s6.ignored");
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 24'hE05555;
        @(posedge clk);
        #1;
        bus.cmd_data  = 24'h903C64;
        @(negedge clk);
        check("s6.rdy_after_ignored", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("s6.rdy_in_scan", 64'(bus.cmd_ready), 64'd0);
        do_reset("s6.reset");
        repeat (NV + 3) @(negedge clk);
        check_table("s6.no_late_update");
        check("s6.steal_quiet", 64'(bus.steal_pulse), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
